// File: rtl/axis_swap_arbiter.sv
// axis_swap_arbiter: packet-granular round-robin arbiter sharing one registered AXI-Stream output, tagging m_dest with the source port.
// Optional feature macro: AXIS_ARB_BYTE_SWAP_EN (per-packet byte reversal of data/keep selected by swap_cfg at arbitration).
module axis_swap_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             s_valid,
    output logic [NUM_PORTS-1:0]             s_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_data,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_keep,
    input  logic [NUM_PORTS-1:0]             s_last,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_user,
    input  logic [NUM_PORTS-1:0]             swap_cfg,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [DATA_WIDTH/8-1:0]          m_keep,
    output logic                             m_last,
    output logic [USER_WIDTH-1:0]            m_user,
    output logic [DEST_WIDTH-1:0]            m_dest,
    output logic                             busy,
    output logic [DEST_WIDTH-1:0]            grant_idx
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DEST_WIDTH-1:0] r_grant;
    logic [DEST_WIDTH-1:0] r_last_grant;
    logic [DEST_WIDTH-1:0] w_pick;
    logic [IW-1:0]         w_g;
    logic                  w_arb;
    logic                  w_out_free;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [KW-1:0]         w_keep;
    logic [KW-1:0]         w_ld_keep;
    logic [USER_WIDTH-1:0] w_user;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [KW-1:0]         r_m_keep;
    logic                  r_m_last;
    logic [USER_WIDTH-1:0] r_m_user;
    logic [DEST_WIDTH-1:0] r_m_dest;

    assign w_g        = r_grant[IW-1:0];
    assign w_arb      = (r_state == IDLE) && (|s_valid);
    assign w_out_free = !r_m_valid || m_ready;
    assign w_data     = s_data[w_g*DATA_WIDTH +: DATA_WIDTH];
    assign w_keep     = s_keep[w_g*KW +: KW];
    assign w_user     = s_user[w_g*USER_WIDTH +: USER_WIDTH];
    assign s_ready    = (r_state == LOCKED && w_out_free) ? (NUM_PORTS'(1) << w_g) : '0;
    assign busy       = (r_state == LOCKED);
    assign grant_idx  = r_grant;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_keep     = r_m_keep;
    assign m_last     = r_m_last;
    assign m_user     = r_m_user;
    assign m_dest     = r_m_dest;

    // round-robin pick: first requester after last_grant; iterating downwards lets the nearest one win
    always_comb begin
        w_pick = r_last_grant;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            if (s_valid[IW'((int'(r_last_grant) + i) % NUM_PORTS)]) w_pick = DEST_WIDTH'((int'(r_last_grant) + i) % NUM_PORTS);
        end
    end

    // next state: lock on any request in IDLE, release after the transfer carrying last
    always_comb begin
        w_xfer = (r_state == LOCKED) && s_valid[w_g] && w_out_free;
        w_next = (r_state == IDLE) ? (w_arb ? LOCKED : IDLE) : ((w_xfer && s_last[w_g]) ? IDLE : LOCKED);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // grant capture on the arbitration edge; round-robin pointer advances when the packet ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= DEST_WIDTH'(NUM_PORTS - 1);
        end else if (w_arb) begin
            r_grant <= w_pick;
        end else if (w_xfer && s_last[w_g]) begin
            r_last_grant <= r_grant;
        end
    end

`ifdef AXIS_ARB_BYTE_SWAP_EN
    logic r_swap;

    // swap choice is frozen for the whole packet at arbitration time
    always_ff @(posedge clk) begin
        if (rst)        r_swap <= 1'b0;
        else if (w_arb) r_swap <= swap_cfg[w_pick[IW-1:0]];
    end

    // byte-reverse data and keep for packets that asked for it
    always_comb begin
        w_ld_data = w_data;
        w_ld_keep = w_keep;
        for (int k = 0; k < KW; k++) begin
            if (r_swap) begin
                w_ld_data[k*8 +: 8] = w_data[(KW-1-k)*8 +: 8];
                w_ld_keep[k +: 1]   = w_keep[(KW-1-k) +: 1];
            end
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^swap_cfg;
    assign w_ld_data = w_data;
    assign w_ld_keep = w_keep;
`endif

    // output stage: load on transfer, otherwise drain when the consumer takes the beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_user  <= '0;
            r_m_dest  <= '0;
        end else if (w_xfer) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_ld_data;
            r_m_keep  <= w_ld_keep;
            r_m_last  <= s_last[w_g];
            r_m_user  <= w_user;
            r_m_dest  <= r_grant;
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
        end
    end
endmodule

// File: doc/axis_swap_arbiter.md
Name: axis_swap_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one downstream AXI-Stream endianness converter between NUM_PORTS requesters.
- Locks the grant on the first beat and holds it until the beat carrying last.
- Drives a registered single-beat output stage and tags each packet with its source index on m_dest.
- Sits between the per-requester stream sources and the shared byte-order converter.

Parameters:
- NUM_PORTS, 4, number of input streams, 2..16
- DATA_WIDTH, 64, data bits per stream, multiple of 8
- USER_WIDTH, 1, sideband user bits per stream
- DEST_WIDTH, 2, m_dest width, must be >= clog2(NUM_PORTS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  NUM_PORTS  per-port valid
- s_ready  out  NUM_PORTS  per-port ready
- s_data  in  NUM_PORTS*DATA_WIDTH  packed data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_keep  in  NUM_PORTS*DATA_WIDTH/8  packed keep
- s_last  in  NUM_PORTS  per-port last
- s_user  in  NUM_PORTS*USER_WIDTH  packed user
- swap_cfg  in  NUM_PORTS  per-port byte-swap request; used only with the optional feature
- m_valid  out  1  output valid (registered)
- m_ready  in  1  output ready
- m_data  out  DATA_WIDTH  output data
- m_keep  out  DATA_WIDTH/8  output keep
- m_last  out  1  output last
- m_user  out  USER_WIDTH  output user
- m_dest  out  DEST_WIDTH  source port index, zero-extended
- busy  out  1  high while in LOCKED
- grant_idx  out  DEST_WIDTH  currently or most recently granted port

Behaviour:
- Reset values:
  - state = IDLE, last_grant = NUM_PORTS-1, so port 0 wins first.
  - m_valid = 0; m_data, m_keep, m_last, m_user and m_dest = 0.
  - busy = 0, grant_idx = 0, s_ready = 0.
- States: IDLE, LOCKED.
- IDLE:
  - s_ready is all 0.
  - If any s_valid is set, choose the first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - Register it into grant_idx and go to LOCKED next cycle.
  - With no requests, stay in IDLE.
- LOCKED:
  - s_ready[grant_idx] = out_free, where out_free = !m_valid || m_ready. All other s_ready bits are 0.
  - A beat transfers on s_valid[g] && s_ready[g]. On the next edge it loads the output register (m_valid=1, fields copied, m_dest = grant_idx).
  - A transfer whose s_last = 1 sets last_grant = grant_idx and returns to IDLE on the same edge.
- Output register:
  - If m_valid && m_ready and no new beat loads, clear m_valid.
  - A simultaneous drain and load keeps m_valid = 1 and holds the new beat.
  - Steady-state throughput is 1 beat/cycle within a packet.
- Latency and fairness:
  - Input beat to m_valid takes 1 cycle.
  - Each packet costs one arbitration bubble (the IDLE cycle).
- Boundary conditions:
  - Granted source drops s_valid mid-packet: remain LOCKED indefinitely, with no timeout and no re-arbitration.
  - m_ready held low: output holds all fields stable and s_ready stays 0. No beat is lost or duplicated.
  - Single-beat packet (s_last on first beat): LOCKED for one transfer only, then IDLE.
  - Only one port requesting: it is re-granted after each IDLE bubble.
  - Requests arriving in the same cycle as the arbitration decision are considered in the next IDLE.
  - rst mid-packet: all state returns to reset values on that edge, and the in-flight beat in the output register is discarded. The downstream converter receives a truncated packet; upstream sources are responsible for resynchronising.
- m_keep and m_user pass through unmodified except under the optional feature.

Optional Feature:
- Macro: AXIS_ARB_BYTE_SWAP_EN.
- Defined:
  - When swap_cfg[grant_idx] is sampled as 1 on the arbitration edge, every beat of that packet is loaded with bytes reversed: m_data byte k = s_data byte (DATA_WIDTH/8-1-k), and m_keep bit k = s_keep bit (DATA_WIDTH/8-1-k).
  - swap_cfg changes during LOCKED do not affect the current packet.
- Undefined:
  - swap_cfg is ignored and data and keep pass straight through.
  - The per-packet swap flop is not instantiated.

Test Plan:
- Reset, then ports 0–3 each present a 2-beat packet at once -> m_dest order 0,1,2,3; 8 beats total; one bubble between packets; s_ready held to a single port at any time.
- Port 2 sends 4-beat packet data 0x11..0x44 while m_ready toggles 1,0,1,0 -> m_data sequence 0x11,0x22,0x33,0x44 with no drop or duplicate; fields stable while m_ready = 0.
- Port 1 drops s_valid for 5 cycles mid-packet while port 3 requests -> busy stays 1, grant_idx = 1, s_ready[3] = 0 until port 1's last beat.
- rst asserted on the 2nd beat of a 3-beat packet -> next cycle m_valid = 0, busy = 0, s_ready = 0; next grant goes to port 0.
- With AXIS_ARB_BYTE_SWAP_EN, swap_cfg = 4'b0001, port 0 sends 0x0102030405060708 with keep 0x0F -> m_data = 0x0807060504030201, m_keep = 0xF0. Port 1 with the same data passes unchanged.
